// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by the PC.
// A prediction is made in ID. The prediction and its table index then move through
// EX and MEM slots, so that they line up with branch resolution in the MEM stage.
// When the branch resolves, its counter is trained, and the saturating performance
// counters are updated.
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_pc,
  input  logic             jump_early,
  input  logic             branch_early,
  input  logic             flush,
  input  logic             branch_resolved,
  input  logic             actual_taken,
  input  logic             mispredict,
  output logic             predict_taken,
  output logic             jump_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [IDX_W-1:0] id_idx;

  logic             ex_valid_q, ex_valid_d;
  logic             ex_pred_q, ex_pred_d;
  logic [IDX_W-1:0] ex_idx_q, ex_idx_d;
  logic             mem_valid_q, mem_valid_d;
  logic             mem_pred_q, mem_pred_d;
  logic [IDX_W-1:0] mem_idx_q, mem_idx_d;

  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  // The mispredict input is informational only; mispredicts are counted from the
  // MEM slot prediction instead. The low PC bits and the high PC bits are not part
  // of the index.
  logic unused_sig;
  assign unused_sig = ^{mispredict, id_pc[31:IDX_W+2], id_pc[1:0]};

  assign id_idx = id_pc[IDX_W+1:2];

  // ID-stage prediction reads the table as it is before any update in this cycle (no bypass).
  always_comb begin
    predict_taken = jump_early | (branch_early & bht_q[id_idx][1]);
  end

  // Move the prediction through the EX and MEM slots; flush empties both slots.
  always_comb begin
    ex_valid_d  = jump_early | branch_early;
    ex_pred_d   = predict_taken;
    ex_idx_d    = id_idx;
    mem_valid_d = ex_valid_q;
    mem_pred_d  = ex_pred_q;
    mem_idx_d   = ex_idx_q;
    if (flush) begin
      ex_valid_d  = 1'b0;
      ex_pred_d   = 1'b0;
      ex_idx_d    = '0;
      mem_valid_d = 1'b0;
      mem_pred_d  = 1'b0;
      mem_idx_d   = '0;
    end
  end

  // Train the counter held in the MEM slot when a branch resolves. An empty slot is never trained.
  always_comb begin
    bht_d = bht_q;
    if (branch_resolved && mem_valid_q) begin
      if (actual_taken) begin
        if (bht_q[mem_idx_q] != 2'b11) bht_d[mem_idx_q] = bht_q[mem_idx_q] + 2'd1;
      end else begin
        if (bht_q[mem_idx_q] != 2'b00) bht_d[mem_idx_q] = bht_q[mem_idx_q] - 2'd1;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (branch_resolved) begin
      if (branch_count_q != '1) branch_count_d = branch_count_q + CNT_W'(1);
      if ((mem_pred_q != actual_taken) && (mispredict_count_q != '1))
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  // State registers. Reset takes priority over flush and over training.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      ex_valid_q         <= 1'b0;
      ex_pred_q          <= 1'b0;
      ex_idx_q           <= '0;
      mem_valid_q        <= 1'b0;
      mem_pred_q         <= 1'b0;
      mem_idx_q          <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      ex_valid_q         <= ex_valid_d;
      ex_pred_q          <= ex_pred_d;
      ex_idx_q           <= ex_idx_d;
      mem_valid_q        <= mem_valid_d;
      mem_pred_q         <= mem_pred_d;
      mem_idx_q          <= mem_idx_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Outputs to the datapath come straight from registers.
  always_comb begin
    jump_taken       = mem_valid_q & mem_pred_q;
    branch_count     = branch_count_q;
    mispredict_count = mispredict_count_q;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. It has two instances that share every input:
// one with 16-bit perf counters and one with 4-bit perf counters, for the saturation case.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc;
  logic        jump_early, branch_early, flush;
  logic        branch_resolved, actual_taken, mispredict;

  logic        predict_taken, jump_taken;
  logic [15:0] branch_count, mispredict_count;
  logic        predict_taken_s, jump_taken_s;
  logic [3:0]  branch_count_s, mispredict_count_s;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .id_pc(id_pc), .jump_early(jump_early),
    .branch_early(branch_early), .flush(flush), .branch_resolved(branch_resolved),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .predict_taken(predict_taken), .jump_taken(jump_taken),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_pc(id_pc), .jump_early(jump_early),
    .branch_early(branch_early), .flush(flush), .branch_resolved(branch_resolved),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .predict_taken(predict_taken_s), .jump_taken(jump_taken_s),
    .branch_count(branch_count_s), .mispredict_count(mispredict_count_s)
  );

  always #5 clk = ~clk;

  // Stimulus helper: look up pc as a branch for a moment without letting it enter EX.
  task automatic probe(input logic [31:0] pc, output logic p);
    id_pc = pc; branch_early = 1'b1;
    #1 p = predict_taken;
    branch_early = 1'b0; id_pc = '0;
  endtask

  // Stimulus helper: a branch goes through ID, EX and MEM, then resolves in MEM.
  // mem_pred returns the jump_taken value seen while the branch sits in MEM.
  task automatic run_branch(input logic [31:0] pc, input logic taken, output logic mem_pred);
    @(negedge clk); id_pc = pc; branch_early = 1'b1;
    @(negedge clk); branch_early = 1'b0; id_pc = '0;
    @(negedge clk); branch_resolved = 1'b1; actual_taken = taken;
    mem_pred = jump_taken;
    @(negedge clk); branch_resolved = 1'b0; actual_taken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic p;
    @(negedge clk); rst = 1'b1; jump_early = 1'b1;
    #1;
    checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL reset_jump_predict: got %b exp 1", predict_taken); end
    jump_early = 1'b0;
    @(negedge clk);
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL reset_jump_taken: got %b exp 0", jump_taken); end
    checks++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", branch_count, mispredict_count); end
    @(negedge clk); rst = 1'b0;
    probe(32'h40, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL reset_branch_predict: got %b exp 0", p); end
    id_pc = 32'h40; branch_early = 1'b1;
    @(negedge clk); branch_early = 1'b0;
    @(negedge clk);
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL reset_branch_mem: got %b exp 0", jump_taken); end
  endtask

  task automatic test_jump();
    logic p;
    @(negedge clk); id_pc = 32'h80; jump_early = 1'b1;
    #1;
    checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL jump_predict: got %b exp 1", predict_taken); end
    @(negedge clk); jump_early = 1'b0; id_pc = '0;
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL jump_ex_stage: got %b exp 0", jump_taken); end
    @(negedge clk);
    checks++; if (jump_taken !== 1'b1) begin errors++; $display("FAIL jump_mem_stage: got %b exp 1", jump_taken); end
    @(negedge clk);
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL jump_after_mem: got %b exp 0", jump_taken); end
    probe(32'h80, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL jump_bht_unchanged: got %b exp 0", p); end
  endtask

  task automatic test_training();
    // Outcomes and the predicted direction after each resolve, for counter 01 at 0x40:
    // T:10 T:11 T:11 N:10 N:01 N:00 N:00 T:01 T:10
    logic outc [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic expp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic mp, p;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_branch(32'h40, outc[i], mp);
      probe(32'h40, p);
      checks++; if (p !== expp[i]) begin errors++; $display("FAIL train_step%0d: got %b exp %b", i, p, expp[i]); end
    end
    probe(32'h44, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL train_neighbor: got %b exp 0", p); end
  endtask

  task automatic test_perf();
    logic mp;
    do_reset();
    run_branch(32'hC0, 1'b1, mp);
    checks++; if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin
      errors++; $display("FAIL perf_nt_pred_taken: got %0d/%0d exp 1/1", branch_count, mispredict_count); end
    run_branch(32'hC0, 1'b0, mp);
    checks++; if (mp !== 1'b1) begin errors++; $display("FAIL perf_mem_pred: got %b exp 1", mp); end
    checks++; if (branch_count !== 16'd2 || mispredict_count !== 16'd2) begin
      errors++; $display("FAIL perf_t_pred_nt: got %0d/%0d exp 2/2", branch_count, mispredict_count); end
    mispredict = 1'b1;
    run_branch(32'hC0, 1'b0, mp);
    mispredict = 1'b0;
    checks++; if (branch_count !== 16'd3 || mispredict_count !== 16'd2) begin
      errors++; $display("FAIL perf_correct: got %0d/%0d exp 3/2", branch_count, mispredict_count); end
  endtask

  task automatic test_flush();
    logic mp, p;
    do_reset();
    run_branch(32'h48, 1'b1, mp);
    @(negedge clk); id_pc = 32'h48; branch_early = 1'b1;
    #1;
    checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL flush_pre_predict: got %b exp 1", predict_taken); end
    @(negedge clk); branch_early = 1'b0; id_pc = '0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (jump_taken !== 1'b0) begin errors++; $display("FAIL flush_jump_taken: got %b exp 0", jump_taken); end
    branch_resolved = 1'b1; actual_taken = 1'b0;
    @(negedge clk); branch_resolved = 1'b0;
    probe(32'h48, p);
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL flush_no_train: got %b exp 1", p); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); branch_resolved = 1'b1; actual_taken = 1'b1;
    end
    @(negedge clk); branch_resolved = 1'b0; actual_taken = 1'b0;
    checks++; if (branch_count_s !== 4'd15) begin errors++; $display("FAIL sat_branch_count: got %0d exp 15", branch_count_s); end
    checks++; if (mispredict_count_s !== 4'd15) begin errors++; $display("FAIL sat_mispredict_count: got %0d exp 15", mispredict_count_s); end
    checks++; if (branch_count !== 16'd20) begin errors++; $display("FAIL wide_branch_count: got %0d exp 20", branch_count); end
    repeat (2) @(negedge clk);
    checks++; if (branch_count_s !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", branch_count_s); end
  endtask

  initial begin
    rst = 1'b1; id_pc = '0; jump_early = 1'b0; branch_early = 1'b0; flush = 1'b0;
    branch_resolved = 1'b0; actual_taken = 1'b0; mispredict = 1'b0;
    test_reset();
    test_jump();
    test_training();
    test_perf();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
